// File: rtl/vector_pkg.sv
// vector_pkg: shared Q11.21 fixed-point vector and RGB888 types, with SCREEN_WIDTH/SCREEN_HEIGHT geometry defaults
`ifndef SCREEN_WIDTH
`define SCREEN_WIDTH 8
`endif
`ifndef SCREEN_HEIGHT
`define SCREEN_HEIGHT 4
`endif
package vector_pkg;
  localparam int FP_FRAC_BITS = 21;
  typedef logic signed [31:0] fp_t;
  typedef struct packed {
    fp_t x;
    fp_t y;
    fp_t z;
  } vec3_t;
  typedef logic [23:0] rgb888_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; ports clk, rst, wr_en/wr_data in, rd_en in, rd_data/empty/count out
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_wr, do_rd;
  assign empty = count == '0;
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (count != (AW+1)'(DEPTH) || do_rd);
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
endmodule

// File: rtl/pixel_shader_stream.sv
// pixel_shader_stream: depth-shades pixels into an AXI4-Stream RGB888 video stream; ports clk, rst, surface_point_in/hit_in/pixel_valid_in in, pixel_ready_out, m_axis_tdata/tvalid/tuser/tlast out, m_axis_tready in, frame_done/overflow out; PIXEL_SHADER_HIT_STATS_EN adds hit_count_out
module pixel_shader_stream
  import vector_pkg::*;
#(
  parameter int      FIFO_DEPTH  = 32,
  parameter int      DEPTH_SHIFT = 3,
  parameter rgb888_t BG_COLOR    = 24'h202040,
  parameter int      SCREEN_W    = `SCREEN_WIDTH,
  parameter int      SCREEN_H    = `SCREEN_HEIGHT
) (
  input  logic        clk,
  input  logic        rst,
  input  vec3_t       surface_point_in,
  input  logic        hit_in,
  input  logic        pixel_valid_in,
  output logic        pixel_ready_out,
  output rgb888_t     m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        frame_done,
  output logic        overflow
`ifdef PIXEL_SHADER_HIT_STATS_EN
  , output logic [31:0] hit_count_out
`endif
);
`ifdef PIXEL_SHADER_HIT_STATS_EN
  localparam int FW = 25;
`else
  localparam int FW = 24;
`endif
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic signed [10:0] d;
  logic [31:0] sh;
  logic [7:0] lum;
  rgb888_t color, shade_color;
  logic shade_valid, accept, fire, last_x, last_y, empty;
  logic [CW-1:0] fifo_count;
  logic [FW-1:0] wr_data, rd_data;
  logic [15:0] x, y;
  logic unused_bits;
  assign unused_bits = ^{surface_point_in.x, surface_point_in.y, surface_point_in.z[FP_FRAC_BITS-1:0]};
  assign d = surface_point_in.z[31:FP_FRAC_BITS];
  assign sh = d[10] ? '0 : {22'd0, d[9:0]} << DEPTH_SHIFT;
  assign lum = 8'hFF - (sh > 32'd255 ? 8'hFF : sh[7:0]);
  assign color = hit_in ? {3{lum}} : BG_COLOR;
  // counting the in-flight shade register keeps one FIFO slot reserved for it
  assign pixel_ready_out = fifo_count + CW'(shade_valid) <= CW'(FIFO_DEPTH - 1);
  assign accept = pixel_valid_in && pixel_ready_out;
  always_ff @(posedge clk)
    if (rst) begin
      shade_valid <= 1'b0;
      shade_color <= '0;
      overflow <= 1'b0;
    end else begin
      shade_valid <= accept;
      if (accept) shade_color <= color;
      if (pixel_valid_in && !pixel_ready_out) overflow <= 1'b1;
    end
`ifdef PIXEL_SHADER_HIT_STATS_EN
  logic shade_hit;
  logic [31:0] hit_cnt;
  assign wr_data = {shade_hit, shade_color};
  always_ff @(posedge clk)
    if (rst) shade_hit <= 1'b0;
    else if (accept) shade_hit <= hit_in;
  always_ff @(posedge clk)
    if (rst) begin
      hit_cnt <= '0;
      hit_count_out <= '0;
    end else if (frame_done) begin
      hit_count_out <= hit_cnt;
      hit_cnt <= 32'(fire && rd_data[24]);
    end else if (fire && rd_data[24]) begin
      hit_cnt <= hit_cnt + 32'd1;
    end
`else
  assign wr_data = shade_color;
`endif
  sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk,
    .rst,
    .wr_en(shade_valid),
    .wr_data,
    .rd_en(m_axis_tready),
    .rd_data,
    .empty,
    .count(fifo_count)
  );
  assign m_axis_tvalid = !empty;
  assign fire = m_axis_tvalid && m_axis_tready;
  assign last_x = x == 16'(SCREEN_W - 1);
  assign last_y = y == 16'(SCREEN_H - 1);
  assign m_axis_tdata = m_axis_tvalid ? rd_data[23:0] : '0;
  assign m_axis_tuser = m_axis_tvalid && x == '0 && y == '0;
  assign m_axis_tlast = m_axis_tvalid && last_x;
  always_ff @(posedge clk)
    if (rst) begin
      x <= '0;
      y <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= fire && last_x && last_y;
      if (fire) begin
        x <= last_x ? '0 : x + 16'd1;
        if (last_x) y <= last_y ? '0 : y + 16'd1;
      end
    end
endmodule
